// File: rtl/fp_stream_accumulator.sv
// fp_stream_accumulator: sums an IEEE-754 single-precision packet through one combinational adder.
// Optional FPACC_SPECIAL_STICKY_EN freezes the sum on the first Inf/NaN element of a packet.
module floatingPointAdder (
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] result
);
  logic        w_xa, w_sub, w_rnd, w_nan_x, w_nan_y, w_inf_x, w_inf_y;
  logic [31:0] w_big, w_sml;
  logic [7:0]  w_eb, w_es, w_d, w_ls;
  logic [5:0]  w_sh;
  logic [23:0] w_fb, w_fs;
  logic [49:0] w_s50;
  logic [26:0] w_s27, w_n;
  logic [27:0] w_mag;
  logic [4:0]  w_lz;
  logic [8:0]  w_e;
  logic [30:0] w_fin;
  always_comb begin
    w_nan_x = (&x[30:23]) & (|x[22:0]);
    w_nan_y = (&y[30:23]) & (|y[22:0]);
    w_inf_x = (&x[30:23]) & ~(|x[22:0]);
    w_inf_y = (&y[30:23]) & ~(|y[22:0]);
    w_xa = x[30:0] >= y[30:0];
    w_big = w_xa ? x : y;
    w_sml = w_xa ? y : x;
    w_eb = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
    w_es = (w_sml[30:23] == 8'd0) ? 8'd1 : w_sml[30:23];
    w_fb = {|w_big[30:23], w_big[22:0]};
    w_fs = {|w_sml[30:23], w_sml[22:0]};
    w_d = w_eb - w_es;
    w_sh = (w_d > 8'd50) ? 6'd50 : w_d[5:0];
    // smaller operand aligned to guard/round bits with everything below folded into sticky
    w_s50 = {w_fs, 26'b0} >> w_sh;
    w_s27 = {w_s50[49:24], |w_s50[23:0]};
    w_sub = x[31] ^ y[31];
    w_mag = w_sub ? {1'b0, w_fb, 3'b0} - {1'b0, w_s27} : {1'b0, w_fb, 3'b0} + {1'b0, w_s27};
    w_lz = 5'd27;
    for (int k = 0; k < 27; k++) if (w_mag[k]) w_lz = 5'(26 - k);
    w_ls = ({3'b0, w_lz} > w_eb - 8'd1) ? w_eb - 8'd1 : {3'b0, w_lz};
    w_n = w_mag[27] ? {w_mag[27:2], |w_mag[1:0]} : w_mag[26:0] << w_ls;
    w_e = w_mag[27] ? {1'b0, w_eb} + 9'd1 : {1'b0, w_eb} - {1'b0, w_ls};
    w_rnd = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
    // rounding carry ripples into the exponent field, covering renormalisation and overflow to Inf
    w_fin = {(w_n[26] ? w_e[7:0] : 8'd0), w_n[25:3]} + {30'b0, w_rnd};
    result = (w_nan_x | w_nan_y | (w_inf_x & w_inf_y & w_sub)) ? 32'h7FC00000 :
             w_inf_x ? x :
             w_inf_y ? y :
             (w_mag == 28'd0) ? {x[31] & y[31], 31'b0} :
             (w_e >= 9'd255) ? {w_big[31], 8'hFF, 23'b0} : {w_big[31], w_fin};
  end
endmodule

module fp_stream_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;
  state_t           r_state, w_next;
  logic [31:0]      r_acc, w_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf, w_accept, w_cnt_max;
`ifdef FPACC_SPECIAL_STICKY_EN
  logic             r_special, w_in_special;
  assign w_in_special = &in_data[30:23];
`endif
  floatingPointAdder u_add (.x(r_acc), .y(in_data), .result(w_sum));
  assign in_ready  = r_state != S_DONE;
  assign out_valid = r_state == S_DONE;
  assign out_data  = r_acc;
  assign out_count = r_cnt;
  assign out_ovf   = r_ovf;
  always_comb begin
    w_accept = in_valid & in_ready;
    w_cnt_max = &r_cnt;
    w_next = r_state;
    if (r_state == S_DONE) w_next = out_ready ? S_IDLE : S_DONE;
    else if (w_accept) w_next = in_last ? S_DONE : S_ACCUM;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc <= 32'h00000000;
      r_cnt <= '0;
      r_ovf <= 1'b0;
`ifdef FPACC_SPECIAL_STICKY_EN
      r_special <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept && r_state == S_IDLE) begin
        r_acc <= in_data;
        r_cnt <= CNT_W'(1);
        r_ovf <= 1'b0;
`ifdef FPACC_SPECIAL_STICKY_EN
        r_special <= w_in_special;
`endif
      end else if (w_accept) begin
        r_cnt <= w_cnt_max ? r_cnt : r_cnt + CNT_W'(1);
        r_ovf <= r_ovf | w_cnt_max;
`ifdef FPACC_SPECIAL_STICKY_EN
        r_acc <= r_special ? r_acc : w_in_special ? in_data : w_sum;
        r_special <= r_special | w_in_special;
`else
        r_acc <= w_sum;
`endif
      end
    end
  end
endmodule

// File: tb/tb_fp_stream_accumulator.sv
// tb_fp_stream_accumulator: random and directed packets checked against an exact integer-sum model.
module tb_fp_stream_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_ovf;
  logic [31:0] out_data;
  logic [7:0]  out_count;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [31:0] out_data_b;
  logic [1:0]  out_count_b;
  typedef struct {logic [31:0] d; int n;} exp_t;
  exp_t q[$];
  int   n_chk = 0, n_pass = 0;
  bit   started = 0, rnd_mode = 0, force_rdy = 1, prev_qv = 0;

  fp_stream_accumulator #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_ovf(out_ovf));
  fp_stream_accumulator #(.CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_count(out_count_b), .out_ovf(out_ovf_b));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
  endtask

  function automatic logic [31:0] i2f(input int v);
    int m, p;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int k = 0; k < 24; k++) if (m >= (1 << k)) p = k;
    return {v < 0, 8'(127 + p), 23'((m << (23 - p)) & 32'h7FFFFF)};
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  always @(negedge clk) begin
    #1;
    out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : force_rdy;
  end

  always @(negedge clk) if (started) begin
    if (!rst_n) q.delete();
    else if (prev_qv && out_ready && q.size() != 0) void'(q.pop_front());
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    chk("out_valid_w2", {31'b0, out_valid_b}, {31'b0, q.size() != 0});
    chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() == 0});
    chk("in_ready_w2", {31'b0, in_ready_b}, {31'b0, q.size() == 0});
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_data_w2", out_data_b, q[0].d);
      chk("out_count", {24'b0, out_count}, 32'(sat(q[0].n, 255)));
      chk("out_count_w2", {30'b0, out_count_b}, 32'(sat(q[0].n, 3)));
      chk("out_ovf", {31'b0, out_ovf}, {31'b0, q[0].n > 255});
      chk("out_ovf_w2", {31'b0, out_ovf_b}, {31'b0, q[0].n > 3});
    end
    prev_qv = q.size() != 0;
  end

  task automatic send_elem(input logic [31:0] d, input logic l);
    int g = 0;
    @(negedge clk); #1;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && g < 100) begin @(negedge clk); #1; g++; end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", g);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; in_valid = 1'b0; in_last = 1'b0; end
  endtask

  task automatic drain;
    int g = 0;
    idle(1);
    while (q.size() != 0 && g < 200) begin @(negedge clk); g++; end
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d sums pending, expected 0", q.size());
    end
    idle(1);
  endtask

  task automatic pkt3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] s);
    send_elem(a, 1'b0);
    send_elem(b, 1'b0);
    send_elem(c, 1'b1);
    q.push_back('{s, 3});
    drain();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    started = 1;
    @(negedge clk); #1 rst_n = 1'b1;
    // directed: 1 + 2 + 1
    pkt3(32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40800000);
    // single element held with out_ready low
    force_rdy = 0;
    send_elem(32'hBF800000, 1'b1);
    q.push_back('{32'hBF800000, 1});
    idle(6);
    force_rdy = 1;
    drain();
    // bubbles inside a packet, exact cancellation
    send_elem(32'h40400000, 1'b0);
    idle(3);
    send_elem(32'hC0400000, 1'b1);
    q.push_back('{32'h00000000, 2});
    drain();
    // reset after two elements discards the partial sum
    send_elem(32'h3F800000, 1'b0);
    send_elem(32'h40000000, 1'b0);
    @(negedge clk); #1 in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    idle(1);
    send_elem(32'h40000000, 1'b1);
    q.push_back('{32'h40000000, 1});
    drain();
    // five ones saturate the 2-bit counter, next packet clears ovf
    for (int i = 0; i < 5; i++) send_elem(32'h3F800000, i == 4);
    q.push_back('{32'h40A00000, 5});
    drain();
    send_elem(32'h3F800000, 1'b1);
    q.push_back('{32'h3F800000, 1});
    drain();
    // special values
    pkt3(32'h3F800000, 32'h7FC00000, 32'h3F800000, 32'h7FC00000);
`ifdef FPACC_SPECIAL_STICKY_EN
    pkt3(32'h3F800000, 32'h7F800001, 32'h3F800000, 32'h7F800001);
    pkt3(32'h40000000, 32'h7F800000, 32'hFF800000, 32'h7F800000);
`else
    pkt3(32'h3F800000, 32'h7F800001, 32'h3F800000, 32'h7FC00000);
    pkt3(32'h40000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000);
`endif
    // random packets of small integers, whose sums are exact in single precision
    rnd_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int len, sum, v;
      len = int'($urandom_range(1, 8));
      sum = 0;
      for (int i = 0; i < len; i++) begin
        v = int'($urandom_range(0, 128)) - 64;
        sum += v;
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        send_elem(i2f(v), i == len - 1);
      end
      q.push_back('{i2f(sum), len});
    end
    drain();
    rnd_mode = 0;
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
